edp_muldiv: RTL

Parametrised iterative multiply/divide datapath for the EBOX, successor to the fixed-width AR/ARX/MQ shift-and-add path in the EDP. It takes a W-bit operand and a 2W-bit operand, then runs a one-bit-per-cycle magnitude multiply or restoring divide with sign fix-up. It returns a 2W-bit product, or a quotient and remainder with KL10-style no-divide detection. It sits beside the EDP and is driven by CTL microcode strobes through a start/done handshake.

---
 rtl/edp_md_pkg.sv | 25 ++
 rtl/edp_muldiv_if.sv | 26 ++
 rtl/edp_md_step.sv | 35 +++
 rtl/edp_muldiv.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/edp_md_pkg.sv
// Shared types and helpers for the EBOX iterative multiply/divide datapath.
package edp_md_pkg;

   localparam int MD_MAXW = 256;

   typedef enum logic [1:0] {
      mdMUL  = 2'd0,
      mdMULU = 2'd1,
      mdDIV  = 2'd2,
      mdDIVU = 2'd3
   } tMDop;

   typedef enum logic [1:0] {
      mdIDLE = 2'd0,
      mdPREP = 2'd1,
      mdRUN  = 2'd2,
      mdFIX  = 2'd3
   } tMDstate;

   // Conditional two's-complement negate; callers pass the operand's sign to get |v|.
   function automatic logic [MD_MAXW-1:0] absW(input logic [MD_MAXW-1:0] v, input logic neg);
      return neg ? ((~v) + MD_MAXW'(1)) : v;
   endfunction

endpackage

// File: rtl/edp_muldiv_if.sv
// Start/done handshake and operand/result bus between CTL and the muldiv datapath.
interface edp_muldiv_if #(parameter int W = 36);

   logic         start;
   logic         abort;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b_hi;
   logic [W-1:0] b_lo;
   logic         busy;
   logic         done;
   logic         no_divide;
   logic [W-1:0] res_hi;
   logic [W-1:0] res_lo;

   modport master (
      output start, abort, op, a, b_hi, b_lo,
      input  busy, done, no_divide, res_hi, res_lo
   );

   modport slave (
      input  start, abort, op, a, b_hi, b_lo,
      output busy, done, no_divide, res_hi, res_lo
   );

endinterface

// File: rtl/edp_md_step.sv
// One iteration of shift-add multiply or shift/trial-subtract restoring divide on {R, Q}.
module edp_md_step #(parameter int W = 36) (
   input  logic         div_mode,
   input  logic [W-1:0] mag_a,
   input  logic [W-1:0] r_in,
   input  logic [W-1:0] q_in,
   output logic [W-1:0] r_out,
   output logic [W-1:0] q_out
);

   logic [W:0] sum;
   logic [W:0] r_ext;
   logic [W:0] trial;
   logic       fits;

   always_comb begin
      sum   = {1'b0, r_in} + (q_in[0] ? {1'b0, mag_a} : '0);
      r_ext = {r_in, q_in[W-1]};
      trial = r_ext - {1'b0, mag_a};
      // A set top bit of the shifted remainder already exceeds any W-bit divisor.
      fits  = r_ext[W] | ~trial[W];
      r_out = sum[W:1];
      q_out = {sum[0], q_in[W-1:1]};
      if (div_mode) begin
         if (fits) begin
            r_out = trial[W-1:0];
            q_out = {q_in[W-2:0], 1'b1};
         end else begin
            r_out = r_ext[W-1:0];
            q_out = {q_in[W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/edp_muldiv.sv
// Iterative signed/unsigned multiply and restoring divide with KL10-style no-divide detection.
//
// state  | meaning
// IDLE   | waiting for start; results held
// PREP   | form magnitudes and signs, no-divide check
// RUN    | W single-bit shift-add / shift-subtract steps
// FIX    | apply sign to product, quotient and remainder
module edp_muldiv #(parameter int W = 36) (
   input  logic        clk,
   input  logic        reset,
   edp_muldiv_if.slave bus
);

   import edp_md_pkg::*;

   localparam int CW = $clog2(W + 1);
   localparam int W2 = 2 * W;

   tMDstate       state_q, state_d;
   tMDop          op_q, op_d;
   logic [W-1:0]  mag_q, mag_d;
   logic [W-1:0]  r_q, r_d;
   logic [W-1:0]  q_q, q_d;
   logic          qsign_q, qsign_d;
   logic          rsign_q, rsign_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          nodiv_q, nodiv_d;
   logic [W-1:0]  res_hi_q, res_hi_d;
   logic [W-1:0]  res_lo_q, res_lo_d;

   logic          is_div, is_sgn, sa, sb;
   logic [W2-1:0] bval, abs_b, fix_prod;
   logic [W-1:0]  abs_a, fix_quo, fix_rem;
   logic [W-1:0]  step_r, step_q;

   // During PREP, mag/r/q still hold the raw a, b_hi, b_lo latched in IDLE.
   assign is_div   = (op_q == mdDIV) || (op_q == mdDIVU);
   assign is_sgn   = (op_q == mdMUL) || (op_q == mdDIV);
   assign sa       = is_sgn & mag_q[W-1];
   assign sb       = is_sgn & (is_div ? r_q[W-1] : q_q[W-1]);
   assign bval     = is_div ? {r_q, q_q} : {{W{q_q[W-1]}}, q_q};
   assign abs_a    = W'(absW(MD_MAXW'(mag_q), sa));
   assign abs_b    = W2'(absW(MD_MAXW'(bval), sb));
   assign fix_prod = W2'(absW(MD_MAXW'({r_q, q_q}), qsign_q));
   assign fix_quo  = W'(absW(MD_MAXW'(q_q), qsign_q));
   assign fix_rem  = W'(absW(MD_MAXW'(r_q), rsign_q));

   edp_md_step #(.W(W)) u_step (
      .div_mode (is_div),
      .mag_a    (mag_q),
      .r_in     (r_q),
      .q_in     (q_q),
      .r_out    (step_r),
      .q_out    (step_q)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mag_d    = mag_q;
      r_d      = r_q;
      q_d      = q_q;
      qsign_d  = qsign_q;
      rsign_d  = rsign_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      nodiv_d  = nodiv_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      if (bus.abort && (state_q != mdIDLE)) begin
         state_d = mdIDLE;
      end else begin
         case (state_q)
            mdIDLE: begin
               if (bus.start) begin
                  state_d = mdPREP;
                  op_d    = tMDop'(bus.op);
                  mag_d   = bus.a;
                  r_d     = bus.b_hi;
                  q_d     = bus.b_lo;
               end
            end
            mdPREP: begin
               if (is_div && ((abs_a == '0) || (abs_b[W2-1:W] >= abs_a))) begin
                  state_d  = mdIDLE;
                  done_d   = 1'b1;
                  nodiv_d  = 1'b1;
                  res_hi_d = r_q;
                  res_lo_d = q_q;
               end else begin
                  state_d = mdRUN;
                  mag_d   = abs_a;
                  qsign_d = sa ^ sb;
                  rsign_d = sb;
                  cnt_d   = '0;
                  if (is_div) begin
                     r_d = abs_b[W2-1:W];
                     q_d = abs_b[W-1:0];
                  end else begin
                     r_d = '0;
                     q_d = abs_b[W-1:0];
                  end
               end
            end
            mdRUN: begin
               r_d = step_r;
               q_d = step_q;
               if (cnt_q == CW'(W - 1)) begin
                  state_d = mdFIX;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            mdFIX: begin
               state_d = mdIDLE;
               done_d  = 1'b1;
               nodiv_d = 1'b0;
               if (is_div) begin
                  res_hi_d = fix_rem;
                  res_lo_d = fix_quo;
               end else begin
                  res_hi_d = fix_prod[W2-1:W];
                  res_lo_d = fix_prod[W-1:0];
               end
            end
            default: state_d = mdIDLE;
         endcase
      end
      busy_d = (state_d != mdIDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= mdIDLE;
         op_q     <= mdMUL;
         mag_q    <= '0;
         r_q      <= '0;
         q_q      <= '0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         nodiv_q  <= 1'b0;
         res_hi_q <= '0;
         res_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mag_q    <= mag_d;
         r_q      <= r_d;
         q_q      <= q_d;
         qsign_q  <= qsign_d;
         rsign_q  <= rsign_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         nodiv_q  <= nodiv_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.no_divide = nodiv_q;
   assign bus.res_hi    = res_hi_q;
   assign bus.res_lo    = res_lo_q;

endmodule
